muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. It sits beside the ALU in execute. The control unit decodes the op, issues a start pulse, and stalls on busy for any MFHI/MFLO or new muldiv op. It generalises the decode-to-function mapping into a parametrised, multi-cycle engine with a handshake.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: owns HI/LO and runs MULT(U)/DIV(U) one bit per cycle.
// MTHI/MTLO and divide-by-zero complete in a single cycle without entering the iterative engine.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               isDiv_q, isDiv_d;
  logic               negLow_q, negLow_d;
  logic               negHigh_q, negHigh_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divZero_q, divZero_d;

  logic [WIDTH-1:0]   absA, absB;
  logic               signedOp;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift, divDiff;
  logic               divFits;
  logic [2*WIDTH-1:0] divNext;
  logic [WIDTH-1:0]   remMag, quotMag;

  assign absA     = a[WIDTH-1] ? -a : a;
  assign absB     = b[WIDTH-1] ? -b : b;
  assign signedOp = ~op[0];

  // acc holds {partial product, remaining multiplier bits}; shift right one bit per step.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

  // For divide, acc holds {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opnd_q};
  assign divFits  = ~divDiff[WIDTH];
  assign divNext  = {(divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], divFits};

  assign remMag  = acc_q[2*WIDTH-1:WIDTH];
  assign quotMag = acc_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    isDiv_d   = isDiv_q;
    negLow_d  = negLow_q;
    negHigh_d = negHigh_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divZero_d = divZero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          divZero_d = 1'b0;
          case (op)
            OP_MULT, OP_MULTU: begin
              opnd_d    = signedOp ? absA : a;
              acc_d     = {{WIDTH{1'b0}}, (signedOp ? absB : b)};
              negLow_d  = signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
              negHigh_d = 1'b0;
              isDiv_d   = 1'b0;
              cnt_d     = CNT_W'(WIDTH);
              state_d   = MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                hi_d      = a;
                lo_d      = '1;
                divZero_d = 1'b1;
                done_d    = 1'b1;
              end else begin
                opnd_d    = signedOp ? absB : b;
                acc_d     = {{WIDTH{1'b0}}, (signedOp ? absA : a)};
                negLow_d  = signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
                negHigh_d = signedOp & a[WIDTH-1];
                isDiv_d   = 1'b1;
                cnt_d     = CNT_W'(WIDTH);
                state_d   = DIV;
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mulNext;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      DIV: begin
        acc_d = divNext;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        if (isDiv_q) begin
          hi_d = negHigh_q ? -remMag : remMag;
          lo_d = negLow_q ? -quotMag : quotMag;
        end else begin
          {hi_d, lo_d} = negLow_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      isDiv_q   <= 1'b0;
      negLow_q  <= 1'b0;
      negHigh_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      isDiv_q   <= isDiv_d;
      negLow_q  <= negLow_d;
      negHigh_q <= negHigh_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = divZero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo,div_zero}; a monitor
// pops and compares on every done pulse. Single-cycle ops are checked directly.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
  } result_t;

  result_t expQ[$];
  int testsRun    = 0;
  int testsFailed = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [2*WIDTH:0] actual,
                             input logic [2*WIDTH:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One-cycle start pulse; returns at the falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [WIDTH-1:0] aIn,
                               input logic [WIDTH-1:0] bIn);
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitResult(input string name, input int expBusy);
    int cycles     = 0;
    int busyCycles = 0;
    while (!done && cycles < 200) begin
      if (busy) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, "_doneSeen"}, (2*WIDTH+1)'(done), (2*WIDTH+1)'(1));
    checkOutput({name, "_busyCycles"}, (2*WIDTH+1)'(busyCycles), (2*WIDTH+1)'(expBusy));
    @(negedge clk);
    checkOutput({name, "_donePulse"}, (2*WIDTH+1)'(done), '0);
  endtask

  task automatic runOp(input string name, input logic [2:0] opIn, input logic [WIDTH-1:0] aIn,
                       input logic [WIDTH-1:0] bIn, input logic [WIDTH-1:0] expHi,
                       input logic [WIDTH-1:0] expLo, input logic expDz, input int expBusy);
    result_t r;
    r.hi = expHi;
    r.lo = expLo;
    r.dz = expDz;
    expQ.push_back(r);
    applyStimulus(opIn, aIn, bIn);
    waitResult(name, expBusy);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    result_t r;
    forever begin
      @(negedge clk);
      if (done) begin
        checkOutput("doneNotBusy", (2*WIDTH+1)'(busy), '0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", (2*WIDTH+1)'(1), '0);
        end else begin
          r = expQ.pop_front();
          checkOutput("result", {hi, lo, div_zero}, r);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    #12;
    checkOutput("resetState", {hi, lo, div_zero}, '0);
    checkOutput("resetBusyDone", (2*WIDTH+1)'({busy, done}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("multuMax", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    runOp("multNeg", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    runOp("multMinMin", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33);
    runOp("divNegPos", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    runOp("divPosNeg", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
    runOp("divu7by2", 3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    runOp("divOverflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
    runOp("divZero", 3'b010, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0);

    applyStimulus(3'b101, 32'd5, 32'd0);
    checkOutput("mtloLo", {hi, lo, div_zero}, {32'h1234, 32'd5, 1'b0});
    checkOutput("mtloNoDone", (2*WIDTH+1)'({busy, done}), '0);

    // A start while busy must be dropped without disturbing the running divide.
    begin
      result_t r;
      r.hi = 32'd2;
      r.lo = 32'd14;
      r.dz = 1'b0;
      expQ.push_back(r);
      applyStimulus(3'b011, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      start = 1'b1;
      op    = 3'b001;
      a     = 32'd1000;
      b     = 32'd3000;
      @(negedge clk);
      start = 1'b0;
      waitResult("divuIgnoreStart", 29);
    end

    applyStimulus(3'b100, 32'hA5A5A5A5, 32'd0);
    checkOutput("mthiHi", {hi, lo, div_zero}, {32'hA5A5A5A5, 32'd14, 1'b0});
    checkOutput("mthiNoDone", (2*WIDTH+1)'({busy, done}), '0);

    runOp("divuZero", 3'b011, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF, 1'b1, 0);
    applyStimulus(3'b111, 32'h99, 32'h1);
    checkOutput("undefOp", {hi, lo, div_zero}, {32'h55, 32'hFFFFFFFF, 1'b0});
    checkOutput("undefNoDone", (2*WIDTH+1)'({busy, done}), '0);

    // Abort a multiply with reset; state must clear without waiting for a clock edge.
    applyStimulus(3'b000, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetHiLo", {hi, lo, div_zero}, '0);
    checkOutput("asyncResetBusyDone", (2*WIDTH+1)'({busy, done}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("multu6x7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);

    repeat (5) @(negedge clk);
    checkOutput("scoreboardEmpty", (2*WIDTH+1)'(expQ.size()), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
